// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage owning the register file and the PC.
// One instruction per cycle over valid/ready in, registered result over
// valid/ready out. Executes NOP, ADD, ADDI and JUMP.
// Optional macro EX_STAGE_EXT_ALU_EN additionally enables SUB, AND, OR, XOR, SLT;
// without it those opcodes take the illegal path.
module ex_stage_pipe #(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter int          IMM_W    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [AW-1:0]    rs1_idx,
  input  logic [AW-1:0]    rs2_idx,
  input  logic [AW-1:0]    rd_idx,
  input  logic             reg_write,
  input  logic [IMM_W-1:0] immediate_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [AW-1:0]    out_rd,
  output logic             out_illegal,
  output logic [XLEN-1:0]  pc
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_JUMP = 4'b0011;
`ifdef EX_STAGE_EXT_ALU_EN
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
`endif

  logic [XLEN-1:0] regs [NUM_REGS];

  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] exec_result;
  logic [XLEN-1:0] pc_next;
  logic            exec_illegal;
  logic            exec_writes;
  logic            rf_we;

  // Downstream handshake: a free or draining result slot lets a new op in
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Register 0 always reads as zero regardless of array contents
  assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];

  assign imm_sext = {{(XLEN-IMM_W){immediate_value[IMM_W-1]}}, immediate_value};
  assign pc_plus4 = pc + XLEN'(4);

  // Jump keeps the PC bits above the immediate field (none when widths match)
  generate
    if (XLEN > IMM_W + 2) begin : g_jump_hi
      assign jump_target = {pc[XLEN-1:IMM_W+2], immediate_value, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {immediate_value, 2'b00};
    end
  endgenerate

  // Opcode decode and ALU: result value, legality, write intent, next PC
  always_comb begin
    exec_result  = '0;
    exec_illegal = 1'b0;
    exec_writes  = 1'b0;
    pc_next      = pc_plus4;
    case (alu_control)
      OP_NOP: begin
        exec_result = '0;
      end
      OP_ADD: begin
        exec_result = rs1_val + rs2_val;
        exec_writes = 1'b1;
      end
      OP_ADDI: begin
        exec_result = rs1_val + imm_sext;
        exec_writes = 1'b1;
      end
      OP_JUMP: begin
        exec_result = pc_plus4;
        exec_writes = 1'b1;
        pc_next     = jump_target;
      end
`ifdef EX_STAGE_EXT_ALU_EN
      OP_SUB: begin
        exec_result = rs1_val - rs2_val;
        exec_writes = 1'b1;
      end
      OP_AND: begin
        exec_result = rs1_val & rs2_val;
        exec_writes = 1'b1;
      end
      OP_OR: begin
        exec_result = rs1_val | rs2_val;
        exec_writes = 1'b1;
      end
      OP_XOR: begin
        exec_result = rs1_val ^ rs2_val;
        exec_writes = 1'b1;
      end
      OP_SLT: begin
        exec_result = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
        exec_writes = 1'b1;
      end
`endif
      default: begin
        exec_illegal = 1'b1;
        exec_result  = '0;
      end
    endcase
  end

  assign rf_we = accept && reg_write && exec_writes && (rd_idx != '0);

  // Register file: cleared on reset, written on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rd_idx] <= exec_result;
    end
  end

  // Result slot and PC: load on accept, drain on transfer, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result      <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
      pc          <= RESET_PC;
    end else if (accept) begin
      out_valid   <= 1'b1;
      result      <= exec_result;
      out_rd      <= rd_idx;
      out_illegal <= exec_illegal;
      pc          <= pc_next;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe with hand-computed expectations.
module tb_ex_stage_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic        reg_write;
  logic [15:0] immediate_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;

  ex_stage_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_control     (alu_control),
    .rs1_idx         (rs1_idx),
    .rs2_idx         (rs2_idx),
    .rd_idx          (rd_idx),
    .reg_write       (reg_write),
    .immediate_value (immediate_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result),
    .out_rd          (out_rd),
    .out_illegal     (out_illegal),
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [15:0] imm);
    in_valid        = v;
    alu_control     = op;
    rd_idx          = rd;
    rs1_idx         = r1;
    rs2_idx         = r2;
    reg_write       = we;
    immediate_value = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full result slot and PC after an edge, one line per transaction
  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic [4:0] rd, input logic ill, input logic [31:0] p);
    chk({tag, ".valid"},   {31'b0, out_valid},   {31'b0, v});
    chk({tag, ".result"},  result,               res);
    chk({tag, ".rd"},      {27'b0, out_rd},      {27'b0, rd});
    chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    chk({tag, ".pc"},      pc,                   p);
    $display("txn %-10s valid=%0b result=%h rd=%0d illegal=%0b pc=%h",
             tag, out_valid, result, out_rd, out_illegal, pc);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
    #12;
    expect_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI r1 = 0 + 0x12
    drive(1'b1, 4'b0010, 5'd1, 5'd0, 5'd0, 1'b1, 16'h0012);
    tick();
    expect_out("addi_r1", 1'b1, 32'h12, 5'd1, 1'b0, 32'h4);
    // ADD r2 = r1 + r1 on the very next cycle
    drive(1'b1, 4'b0001, 5'd2, 5'd1, 5'd1, 1'b1, 16'h0);
    tick();
    expect_out("add_r2", 1'b1, 32'h24, 5'd2, 1'b0, 32'h8);
    // ADDI r3 = sext(0xFFFF)
    drive(1'b1, 4'b0010, 5'd3, 5'd0, 5'd0, 1'b1, 16'hFFFF);
    tick();
    expect_out("addi_neg", 1'b1, 32'hFFFFFFFF, 5'd3, 1'b0, 32'hC);
    // ADD r4 = r3 + r3 wraps
    drive(1'b1, 4'b0001, 5'd4, 5'd3, 5'd3, 1'b1, 16'h0);
    tick();
    expect_out("add_wrap", 1'b1, 32'hFFFFFFFE, 5'd4, 1'b0, 32'h10);
    // JUMP from pc=0x10 to 0x84, link 0x14 into r5
    drive(1'b1, 4'b0011, 5'd5, 5'd0, 5'd0, 1'b1, 16'h0021);
    tick();
    expect_out("jump", 1'b1, 32'h14, 5'd5, 1'b0, 32'h84);
    // Read back r5 through ADD r6 = r5 + r0
    drive(1'b1, 4'b0001, 5'd6, 5'd5, 5'd0, 1'b1, 16'h0);
    tick();
    expect_out("rd_r5", 1'b1, 32'h14, 5'd6, 1'b0, 32'h88);
    // ADDI into r0 shows computed value but must not stick
    drive(1'b1, 4'b0010, 5'd0, 5'd1, 5'd0, 1'b1, 16'h0005);
    tick();
    expect_out("wr_r0", 1'b1, 32'h17, 5'd0, 1'b0, 32'h8C);
    // ADD r7 = r0 + r4 confirms r0 still reads zero
    drive(1'b1, 4'b0001, 5'd7, 5'd0, 5'd4, 1'b1, 16'h0);
    tick();
    expect_out("rd_r0", 1'b1, 32'hFFFFFFFE, 5'd7, 1'b0, 32'h90);

    // Backpressure: ADDI r8 = r8 + 1 held off for 3 cycles
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 5'd8, 5'd8, 5'd0, 1'b1, 16'h0001);
    #1;
    chk("hold.in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("hold", 1'b1, 32'hFFFFFFFE, 5'd7, 1'b0, 32'h90);
      chk("hold.in_ready_cyc", {31'b0, in_ready}, 32'd0);
    end
    // Release: the held ADDI executes exactly once, then again back-to-back
    out_ready = 1'b1;
    tick();
    expect_out("release1", 1'b1, 32'h1, 5'd8, 1'b0, 32'h94);
    tick();
    expect_out("release2", 1'b1, 32'h2, 5'd8, 1'b0, 32'h98);

    // Opcode 0100 with r1=18, r2=36
    drive(1'b1, 4'b0100, 5'd10, 5'd1, 5'd2, 1'b1, 16'h0);
    tick();
`ifdef EX_STAGE_EXT_ALU_EN
    expect_out("sub", 1'b1, 32'hFFFFFFEE, 5'd10, 1'b0, 32'h9C);
`else
    expect_out("op4_illeg", 1'b1, 32'h0, 5'd10, 1'b1, 32'h9C);
`endif
    // Read back r10
    drive(1'b1, 4'b0001, 5'd11, 5'd10, 5'd0, 1'b1, 16'h0);
    tick();
`ifdef EX_STAGE_EXT_ALU_EN
    expect_out("rd_r10", 1'b1, 32'hFFFFFFEE, 5'd11, 1'b0, 32'hA0);
`else
    expect_out("rd_r10", 1'b1, 32'h0, 5'd11, 1'b0, 32'hA0);
`endif
    // Opcode 1111 is illegal in every build; r12 must stay zero
    drive(1'b1, 4'b1111, 5'd12, 5'd1, 5'd2, 1'b1, 16'h0);
    tick();
    expect_out("op15", 1'b1, 32'h0, 5'd12, 1'b1, 32'hA4);
    // NOP with reg_write set must not write r13
    drive(1'b1, 4'b0000, 5'd13, 5'd1, 5'd1, 1'b1, 16'h0);
    tick();
    expect_out("nop", 1'b1, 32'h0, 5'd13, 1'b0, 32'hA8);
    // r12 + r13 must both be zero
    drive(1'b1, 4'b0001, 5'd14, 5'd12, 5'd13, 1'b1, 16'h0);
    tick();
    expect_out("rd_r12_13", 1'b1, 32'h0, 5'd14, 1'b0, 32'hAC);
    // Transfer with no accept drains the slot; PC holds
    drive(1'b0, 4'b0001, 5'd15, 5'd1, 5'd1, 1'b1, 16'h0);
    tick();
    expect_out("drain", 1'b0, 32'h0, 5'd14, 1'b0, 32'hAC);
    tick();
    expect_out("idle", 1'b0, 32'h0, 5'd14, 1'b0, 32'hAC);

    // Accept one op, hold it, then reset asynchronously mid-cycle
    drive(1'b1, 4'b0010, 5'd9, 5'd1, 5'd0, 1'b1, 16'h0003);
    tick();
    expect_out("pre_rst", 1'b1, 32'h15, 5'd9, 1'b0, 32'hB0);
    out_ready = 1'b0;
    drive(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    // Registers are cleared: r1 + r2 is zero now
    drive(1'b1, 4'b0001, 5'd3, 5'd1, 5'd2, 1'b1, 16'h0);
    tick();
    expect_out("post_rst", 1'b1, 32'h0, 5'd3, 1'b0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
